// File: rtl/tcdm_bridge_slave_responder_pkg.sv
// Shared types and helpers for the TCDM bridge slave responder.
// Holds the in-order response-tracking entry and a ceil-log2 width helper.
package tcdm_bridge_slave_responder_pkg;

    localparam int unsigned RESP_ID_WIDTH  = 16;
    localparam int unsigned RESP_AUX_WIDTH = 32;

    typedef struct packed {
        logic [RESP_ID_WIDTH-1:0]  id;
        logic [RESP_AUX_WIDTH-1:0] aux;
        logic                      wen;
    } resp_entry_t;

    function automatic int unsigned tcdm_clog2(input int unsigned value);
        int unsigned width;
        width = 0;
        while ((64'd1 << width) < 64'(value)) begin
            width = width + 1;
        end
        return width;
    endfunction

endpackage

// File: rtl/tcdm_bridge_slave_responder_if.sv
// Bundles the upstream request/response channel and the downstream memory port.
// The slave modport is the responder's view; master is the surrounding environment.
interface tcdm_bridge_slave_responder_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned BE_WIDTH   = DATA_WIDTH / 8,
    parameter int unsigned ID_WIDTH   = 16,
    parameter int unsigned AUX_WIDTH  = 32
);

    logic                  data_req_i;
    logic [ADDR_WIDTH-1:0] data_add_i;
    logic                  data_wen_i;
    logic [DATA_WIDTH-1:0] data_wdata_i;
    logic [BE_WIDTH-1:0]   data_be_i;
    logic [ID_WIDTH-1:0]   data_ID_i;
    logic [AUX_WIDTH-1:0]  data_aux_i;
    logic                  data_gnt_o;
    logic                  data_r_valid_o;
    logic [ID_WIDTH-1:0]   data_r_ID_o;
    logic [DATA_WIDTH-1:0] data_r_rdata_o;
    logic [AUX_WIDTH-1:0]  data_r_aux_o;

    logic                  mem_req_o;
    logic [ADDR_WIDTH-1:0] mem_add_o;
    logic                  mem_wen_o;
    logic [DATA_WIDTH-1:0] mem_wdata_o;
    logic [BE_WIDTH-1:0]   mem_be_o;
    logic                  mem_gnt_i;
    logic                  mem_r_valid_i;
    logic [DATA_WIDTH-1:0] mem_r_rdata_i;

    logic                  err_o;

    modport slave (
        input  data_req_i, data_add_i, data_wen_i, data_wdata_i, data_be_i, data_ID_i, data_aux_i,
        output data_gnt_o, data_r_valid_o, data_r_ID_o, data_r_rdata_o, data_r_aux_o,
        output mem_req_o, mem_add_o, mem_wen_o, mem_wdata_o, mem_be_o,
        input  mem_gnt_i, mem_r_valid_i, mem_r_rdata_i,
        output err_o
    );

    modport master (
        output data_req_i, data_add_i, data_wen_i, data_wdata_i, data_be_i, data_ID_i, data_aux_i,
        input  data_gnt_o, data_r_valid_o, data_r_ID_o, data_r_rdata_o, data_r_aux_o,
        input  mem_req_o, mem_add_o, mem_wen_o, mem_wdata_o, mem_be_o,
        output mem_gnt_i, mem_r_valid_i, mem_r_rdata_i,
        input  err_o
    );

endinterface

// File: rtl/bridge_resp_id_fifo.sv
// Generic synchronous FIFO with a registered occupancy count and first-word head view.
// Push while full and pop while empty are ignored so the count can never wrap.
module bridge_resp_id_fifo
    import tcdm_bridge_slave_responder_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = tcdm_clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] storage [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign head    = storage[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                storage[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                storage[wr_ptr] <= data_in;
                wr_ptr          <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/tcdm_bridge_slave_responder.sv
// Slave-side responder: gates grants on FIFO space, forwards requests downstream and
// returns in-order responses tagged with the ID/aux captured at grant time.
module tcdm_bridge_slave_responder
    import tcdm_bridge_slave_responder_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned BE_WIDTH        = DATA_WIDTH / 8,
    parameter int unsigned ID_WIDTH        = RESP_ID_WIDTH,
    parameter int unsigned AUX_WIDTH       = RESP_AUX_WIDTH,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input logic                          clk,
    input logic                          rst_n,
    tcdm_bridge_slave_responder_if.slave bus
);

    localparam int unsigned ENTRY_W = $bits(resp_entry_t);

    logic                  full;
    logic                  empty;
    logic                  gnt;
    logic                  push;
    logic                  pop;
    resp_entry_t           push_entry;
    resp_entry_t           head_entry;
    logic [ENTRY_W-1:0]    head_bits;

    logic [ADDR_WIDTH-1:0] fwd_add;
    logic [DATA_WIDTH-1:0] fwd_wdata;
    logic [BE_WIDTH-1:0]   fwd_be;
    logic [ID_WIDTH-1:0]   req_id;
    logic [AUX_WIDTH-1:0]  req_aux;

    logic                  r_valid;
    logic [ID_WIDTH-1:0]   r_id;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [AUX_WIDTH-1:0]  r_aux;
    logic                  err;

    // Grant depends only on the registered full flag, so a pop never opens space the same cycle.
    assign gnt  = bus.mem_gnt_i & ~full;
    assign push = bus.data_req_i & gnt;
    assign pop  = bus.mem_r_valid_i & ~empty;

    assign fwd_add   = bus.data_add_i;
    assign fwd_wdata = bus.data_wdata_i;
    assign fwd_be    = bus.data_be_i;
    assign req_id    = bus.data_ID_i;
    assign req_aux   = bus.data_aux_i;

    assign bus.mem_req_o   = bus.data_req_i & ~full;
    assign bus.mem_add_o   = fwd_add;
    assign bus.mem_wen_o   = bus.data_wen_i;
    assign bus.mem_wdata_o = fwd_wdata;
    assign bus.mem_be_o    = fwd_be;
    assign bus.data_gnt_o  = gnt;

    assign push_entry.id  = req_id;
    assign push_entry.aux = req_aux;
    assign push_entry.wen = bus.data_wen_i;
    assign head_entry     = resp_entry_t'(head_bits);

    bridge_resp_id_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (ENTRY_W)
    ) u_id_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push),
        .pop     (pop),
        .data_in (push_entry),
        .head    (head_bits),
        .full    (full),
        .empty   (empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_id    <= '0;
            r_rdata <= '0;
            r_aux   <= '0;
            err     <= 1'b0;
        end else begin
            r_valid <= pop;
            if (pop) begin
                r_id    <= head_entry.id;
                r_aux   <= head_entry.aux;
                r_rdata <= head_entry.wen ? bus.mem_r_rdata_i : '0;
            end
            // A response with nothing outstanding is a downstream protocol violation; sticky.
            if (bus.mem_r_valid_i && empty) begin
                err <= 1'b1;
            end
        end
    end

    assign bus.data_r_valid_o = r_valid;
    assign bus.data_r_ID_o    = r_id;
    assign bus.data_r_rdata_o = r_rdata;
    assign bus.data_r_aux_o   = r_aux;
    assign bus.err_o          = err;

endmodule

// File: tb/tb_tcdm_bridge_slave_responder.sv
// Directed self-checking bench for tcdm_bridge_slave_responder.
module tb_tcdm_bridge_slave_responder;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_mis;

    tcdm_bridge_slave_responder_if #(
        .ADDR_WIDTH (32), .DATA_WIDTH (32), .BE_WIDTH (4), .ID_WIDTH (16), .AUX_WIDTH (32)
    ) bus ();

    tcdm_bridge_slave_responder #(
        .ADDR_WIDTH (32), .DATA_WIDTH (32), .BE_WIDTH (4), .ID_WIDTH (16), .AUX_WIDTH (32),
        .MAX_OUTSTANDING (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: observed no finish, expected finish before 100000");
        $fatal(1, "bench time limit expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_resp(input string tag, input logic [15:0] id, input logic [31:0] aux,
                              input logic [31:0] rdata);
        check({tag, " r_valid"}, 64'(bus.data_r_valid_o), 64'd1);
        check({tag, " r_ID"},    64'(bus.data_r_ID_o),    64'(id));
        check({tag, " r_aux"},   64'(bus.data_r_aux_o),   64'(aux));
        check({tag, " r_rdata"}, 64'(bus.data_r_rdata_o), 64'(rdata));
    endtask

    task automatic drive_req(input logic req, input logic wen, input logic [15:0] id,
                             input logic [31:0] aux);
        bus.data_req_i = req;
        bus.data_wen_i = wen;
        bus.data_ID_i  = id;
        bus.data_aux_i = aux;
    endtask

    initial begin
        logic [15:0] fill_ids [4];
        fill_ids = '{16'h0002, 16'h0004, 16'h0008, 16'h0010};
        n_cmp = 0;
        n_mis = 0;

        rst_n              = 1'b0;
        bus.data_req_i     = 1'b0;
        bus.data_add_i     = '0;
        bus.data_wen_i     = 1'b0;
        bus.data_wdata_i   = '0;
        bus.data_be_i      = '0;
        bus.data_ID_i      = '0;
        bus.data_aux_i     = '0;
        bus.mem_gnt_i      = 1'b0;
        bus.mem_r_valid_i  = 1'b0;
        bus.mem_r_rdata_i  = '0;

        // Reset state
        tick();
        tick();
        check("rst gnt",     64'(bus.data_gnt_o),     64'd0);
        check("rst r_valid", 64'(bus.data_r_valid_o), 64'd0);
        check("rst r_ID",    64'(bus.data_r_ID_o),    64'd0);
        check("rst r_rdata", 64'(bus.data_r_rdata_o), 64'd0);
        check("rst r_aux",   64'(bus.data_r_aux_o),   64'd0);
        check("rst err",     64'(bus.err_o),          64'd0);
        check("rst mem_req", 64'(bus.mem_req_o),      64'd0);
        rst_n = 1'b1;
        tick();

        // Single read, response three cycles after grant
        drive_req(1'b1, 1'b1, 16'h0004, 32'h0000_00A5);
        bus.data_add_i = 32'h0000_0100;
        bus.mem_gnt_i  = 1'b1;
        #1;
        check("rd gnt",     64'(bus.data_gnt_o), 64'd1);
        check("rd mem_req", 64'(bus.mem_req_o),  64'd1);
        check("rd mem_add", 64'(bus.mem_add_o),  64'h100);
        check("rd mem_wen", 64'(bus.mem_wen_o),  64'd1);
        tick();
        drive_req(1'b0, 1'b1, 16'h0000, 32'h0);
        bus.mem_gnt_i = 1'b0;
        tick();
        tick();
        bus.mem_r_valid_i = 1'b1;
        bus.mem_r_rdata_i = 32'hDEAD_BEEF;
        #1;
        check("rd early r_valid", 64'(bus.data_r_valid_o), 64'd0);
        tick();
        check_resp("rd", 16'h0004, 32'h0000_00A5, 32'hDEAD_BEEF);
        bus.mem_r_valid_i = 1'b0;
        tick();
        check("rd pulse end", 64'(bus.data_r_valid_o), 64'd0);
        check("rd ID hold",   64'(bus.data_r_ID_o),    64'h4);

        // Write: returned data is masked to zero
        drive_req(1'b1, 1'b0, 16'h0001, 32'h0000_0011);
        bus.data_wdata_i = 32'h1234_5678;
        bus.data_be_i    = 4'h5;
        bus.mem_gnt_i    = 1'b1;
        #1;
        check("wr mem_wdata", 64'(bus.mem_wdata_o), 64'h1234_5678);
        check("wr mem_be",    64'(bus.mem_be_o),    64'h5);
        check("wr mem_wen",   64'(bus.mem_wen_o),   64'd0);
        tick();
        drive_req(1'b0, 1'b1, 16'h0000, 32'h0);
        bus.mem_r_valid_i = 1'b1;
        bus.mem_r_rdata_i = 32'hFFFF_FFFF;
        tick();
        check_resp("wr", 16'h0001, 32'h0000_0011, 32'h0);
        bus.mem_r_valid_i = 1'b0;
        tick();

        // Fill to four outstanding, then the fifth request is refused
        drive_req(1'b1, 1'b1, 16'h0001, 32'h0);
        #1;
        check("fill gnt0", 64'(bus.data_gnt_o), 64'd1);
        tick();
        for (int i = 0; i < 3; i++) begin
            bus.data_ID_i = fill_ids[i];
            #1;
            check("fill gnt", 64'(bus.data_gnt_o), 64'd1);
            tick();
        end
        bus.data_ID_i     = 16'h0010;
        bus.mem_r_valid_i = 1'b1;
        bus.mem_r_rdata_i = 32'h0000_00A0;
        #1;
        check("full gnt",     64'(bus.data_gnt_o), 64'd0);
        check("full mem_req", 64'(bus.mem_req_o),  64'd0);
        tick();
        check_resp("full pop", 16'h0001, 32'h0, 32'h0000_00A0);
        bus.mem_r_valid_i = 1'b0;
        #1;
        check("after pop gnt", 64'(bus.data_gnt_o), 64'd1);
        tick();
        drive_req(1'b0, 1'b1, 16'h0000, 32'h0);
        for (int i = 0; i < 4; i++) begin
            bus.mem_r_valid_i = 1'b1;
            bus.mem_r_rdata_i = 32'h0000_00B0 + 32'(i);
            tick();
            check_resp("drain", fill_ids[i], 32'h0, 32'h0000_00B0 + 32'(i));
        end
        bus.mem_r_valid_i = 1'b0;
        tick();
        check("drain idle", 64'(bus.data_r_valid_o), 64'd0);
        check("drain err",  64'(bus.err_o),          64'd0);

        // Streaming: 20 requests with 1-cycle response latency, no bubbles
        for (int k = 0; k <= 20; k++) begin
            drive_req(k < 20, 1'b1, 16'(1 << (k % 16)), 32'(k));
            bus.mem_r_valid_i = (k >= 1);
            bus.mem_r_rdata_i = 32'h0000_C000 + 32'(k - 1);
            #1;
            if (k < 20) check("stream gnt", 64'(bus.data_gnt_o), 64'd1);
            tick();
            if (k >= 1) check_resp("stream", 16'(1 << ((k - 1) % 16)), 32'(k - 1),
                                   32'h0000_C000 + 32'(k - 1));
        end
        drive_req(1'b0, 1'b1, 16'h0000, 32'h0);
        bus.mem_r_valid_i = 1'b0;
        tick();
        check("stream idle", 64'(bus.data_r_valid_o), 64'd0);
        check("stream err",  64'(bus.err_o),          64'd0);

        // Reset with three transactions still outstanding
        drive_req(1'b1, 1'b1, 16'h0020, 32'h0);
        tick();
        bus.data_ID_i = 16'h0040;
        tick();
        bus.data_ID_i = 16'h0080;
        tick();
        bus.data_ID_i = 16'h0100;
        tick();
        drive_req(1'b0, 1'b1, 16'h0000, 32'h0);
        bus.mem_r_valid_i = 1'b1;
        bus.mem_r_rdata_i = 32'h0000_0055;
        tick();
        check_resp("pre-rst", 16'h0020, 32'h0, 32'h0000_0055);
        bus.mem_r_valid_i = 1'b0;
        bus.mem_gnt_i     = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("mid rst r_valid", 64'(bus.data_r_valid_o), 64'd0);
        check("mid rst r_ID",    64'(bus.data_r_ID_o),    64'd0);
        check("mid rst r_rdata", 64'(bus.data_r_rdata_o), 64'd0);
        check("mid rst gnt",     64'(bus.data_gnt_o),     64'd0);
        check("mid rst mem_req", 64'(bus.mem_req_o),      64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        drive_req(1'b1, 1'b1, 16'h0200, 32'h0000_0077);
        bus.mem_gnt_i = 1'b1;
        #1;
        check("post rst gnt", 64'(bus.data_gnt_o), 64'd1);
        tick();
        drive_req(1'b0, 1'b1, 16'h0000, 32'h0);
        bus.mem_r_valid_i = 1'b1;
        bus.mem_r_rdata_i = 32'h0000_0099;
        tick();
        check_resp("post rst", 16'h0200, 32'h0000_0077, 32'h0000_0099);
        bus.mem_r_valid_i = 1'b0;
        tick();
        check("post rst err", 64'(bus.err_o), 64'd0);

        // Spurious response with the FIFO empty
        bus.mem_r_valid_i = 1'b1;
        bus.mem_r_rdata_i = 32'h0000_1234;
        tick();
        check("spur err",     64'(bus.err_o),          64'd1);
        check("spur r_valid", 64'(bus.data_r_valid_o), 64'd0);
        bus.mem_r_valid_i = 1'b0;
        drive_req(1'b1, 1'b1, 16'h0002, 32'h0000_0003);
        tick();
        drive_req(1'b0, 1'b1, 16'h0000, 32'h0);
        bus.mem_r_valid_i = 1'b1;
        bus.mem_r_rdata_i = 32'h0000_4321;
        tick();
        check_resp("after spur", 16'h0002, 32'h0000_0003, 32'h0000_4321);
        bus.mem_r_valid_i = 1'b0;
        tick();
        tick();
        check("err sticky", 64'(bus.err_o), 64'd1);
        rst_n = 1'b0;
        #1;
        check("err cleared", 64'(bus.err_o), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
